// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file: FSM state encoding,
// default sizes and the highest-port-wins selector used by both write and bypass paths.
package regfile_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

    localparam int XLEN_DEF     = 32;
    localparam int NUM_REGS_DEF = 32;

    // Upper bound on write ports handled by the selector below.
    localparam int MAX_PORTS = 8;
    localparam int PORT_SELW = 3;

    function automatic logic [PORT_SELW-1:0] hi_port(input logic [MAX_PORTS-1:0] hits);
        logic [PORT_SELW-1:0] sel;
        sel = '0;
        for (int p = 0; p < MAX_PORTS; p++) begin
            if (hits[p]) sel = PORT_SELW'(p);
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reservations set, write-backs release, reservation
// wins on a same-cycle collision, and an in-flight write-back reads as not busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NUM_REGS = NUM_REGS_DEF,
    parameter  int NUM_RD   = 2,
    parameter  int NUM_WR   = 2,
    localparam int IDXW     = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run_i,
    input  logic [NUM_RD*IDXW-1:0] rd_idx_i,
    input  logic [NUM_WR-1:0]      wr_en_i,
    input  logic [NUM_WR*IDXW-1:0] wr_idx_i,
    input  logic                   rsv_en_i,
    input  logic [IDXW-1:0]        rsv_idx_i,
    output logic [NUM_RD-1:0]      rd_busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // wr_en_i arrives already gated by run_i from the top level.
    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en_i[p]) busy_d[wr_idx_i[p*IDXW +: IDXW]] = 1'b0;
        end
        if (run_i && rsv_en_i) busy_d[rsv_idx_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    always_comb begin
        rd_busy_o = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            logic [IDXW-1:0] ridx;
            logic            wr_hit;
            ridx   = rd_idx_i[i*IDXW +: IDXW];
            wr_hit = 1'b0;
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en_i[p] && (wr_idx_i[p*IDXW +: IDXW] == ridx)) wr_hit = 1'b1;
            end
            rd_busy_o[i] = run_i & busy_q[ridx] & ~wr_hit;
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port integer register file with write-back bypass, x0 hardwired to zero,
// a post-reset sequential clear of the array and a busy scoreboard for decode.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int NUM_REGS = NUM_REGS_DEF,
    parameter  int NUM_RD   = 2,
    parameter  int NUM_WR   = 2,
    localparam int IDXW     = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   ready,
    input  logic [NUM_RD*IDXW-1:0] rd_idx,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic [NUM_WR-1:0]      wr_en,
    input  logic [NUM_WR*IDXW-1:0] wr_idx,
    input  logic [NUM_WR*XLEN-1:0] wr_data,
    input  logic                   rsv_en,
    input  logic [IDXW-1:0]        rsv_idx
);

    logic [XLEN-1:0]     mem_q [NUM_REGS];
    rf_state_e           state_q;
    logic [IDXW-1:0]     clr_cnt_q;
    logic                run;
    logic [NUM_WR-1:0]   wr_act;
    logic [NUM_REGS-1:0] we_d;
    logic [XLEN-1:0]     wdat_d [NUM_REGS];

    assign run    = (state_q == RUN);
    assign ready  = run;
    assign wr_act = run ? wr_en : '0;

    function automatic logic [MAX_PORTS-1:0] port_hits(input logic [IDXW-1:0]        idx,
                                                       input logic [NUM_WR-1:0]      en,
                                                       input logic [NUM_WR*IDXW-1:0] widx);
        logic [MAX_PORTS-1:0] hits;
        hits = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            hits[p] = en[p] && (widx[p*IDXW +: IDXW] == idx);
        end
        return hits;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INIT;
            clr_cnt_q <= '0;
        end else if (state_q == INIT) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (clr_cnt_q == IDXW'(NUM_REGS - 1)) state_q <= RUN;
        end
    end

    // Per-entry write decode; entry 0 is never enabled so x0 writes are dropped.
    always_comb begin
        we_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            logic [MAX_PORTS-1:0] hits;
            hits      = port_hits(IDXW'(r), wr_act, wr_idx);
            we_d[r]   = (r != 0) && (|hits);
            wdat_d[r] = wr_data[int'(hi_port(hits))*XLEN +: XLEN];
        end
    end

    // Storage carries no reset; the INIT walk zeroes it instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == INIT) begin
                mem_q[clr_cnt_q] <= '0;
            end else begin
                for (int r = 1; r < NUM_REGS; r++) begin
                    if (we_d[r]) mem_q[r] <= wdat_d[r];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            logic [IDXW-1:0]      ridx;
            logic [MAX_PORTS-1:0] hits;
            ridx = rd_idx[i*IDXW +: IDXW];
            hits = port_hits(ridx, wr_act, wr_idx);
            if (run && (ridx != '0)) begin
                if (|hits) rd_data[i*XLEN +: XLEN] = wr_data[int'(hi_port(hits))*XLEN +: XLEN];
                else       rd_data[i*XLEN +: XLEN] = mem_q[ridx];
            end
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .run_i     (run),
        .rd_idx_i  (rd_idx),
        .wr_en_i   (wr_act),
        .wr_idx_i  (wr_idx),
        .rsv_en_i  (rsv_en),
        .rsv_idx_i (rsv_idx),
        .rd_busy_o (rd_busy)
    );

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport at default sizes (32 x 32 bit, 2 read, 2 write ports).
module tb_regfile_multiport;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [9:0]  rd_idx;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_idx;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_idx;

    int errors = 0;
    int checks = 0;

    regfile_multiport dut (
        .clk     (clk),
        .rst     (rst),
        .ready   (ready),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .rd_busy (rd_busy),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rsv_en  (rsv_en),
        .rsv_idx (rsv_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [4:0] idx);
        rd_idx[p*5 +: 5] = idx;
    endtask

    task automatic set_wr(input int p, input logic en, input logic [4:0] idx, input logic [31:0] d);
        wr_en[p]           = en;
        wr_idx[p*5 +: 5]   = idx;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic idle();
        wr_en  = '0;
        rsv_en = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        wr_idx = '0; wr_data = '0; rsv_idx = '0; rd_idx = '0;
        tick(); tick();
        set_rd(0, 5'd5); set_rd(1, 5'd31);
        #1;
        checks++;
        if (ready !== 1'b0 || rd_data !== 64'h0 || rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: ready=%b rd_data=%h rd_busy=%b, want 0/0/0", ready, rd_data, rd_busy);
        end
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            checks++;
            if (ready !== ((k == 32) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL init_ready edge %0d: ready=%b want %b", k, ready, (k == 32));
            end
        end
        for (int r = 0; r < 32; r++) begin
            set_rd(0, 5'(r));
            #1;
            checks++;
            if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
                errors++;
                $display("FAIL cleared_x%0d: data=%h busy=%b want 0/0", r, rd_data[31:0], rd_busy[0]);
            end
        end
    endtask

    task automatic test_write_bypass();
        set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
        set_rd(0, 5'd5); set_rd(1, 5'd6);
        #2;
        checks++;
        if (rd_data[31:0] !== 32'hDEADBEEF || rd_data[63:32] !== 32'h0) begin
            errors++;
            $display("FAIL bypass_x5: got %h/%h want deadbeef/00000000", rd_data[31:0], rd_data[63:32]);
        end
        tick();
        idle();
        set_rd(1, 5'd5);
        #1;
        checks++;
        if (rd_data[31:0] !== 32'hDEADBEEF || rd_data[63:32] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL array_x5: got %h/%h want deadbeef/deadbeef", rd_data[31:0], rd_data[63:32]);
        end
        set_wr(0, 1'b1, 5'd0, 32'h1234);
        set_rd(0, 5'd0);
        #2;
        checks++;
        if (rd_data[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL x0_bypass: got %h want 0", rd_data[31:0]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL x0_array: got %h want 0", rd_data[31:0]);
        end
    endtask

    task automatic test_same_index();
        set_wr(0, 1'b1, 5'd7, 32'h11);
        set_wr(1, 1'b1, 5'd7, 32'h22);
        set_rd(0, 5'd7); set_rd(1, 5'd7);
        #2;
        checks++;
        if (rd_data !== {32'h22, 32'h22}) begin
            errors++;
            $display("FAIL collide_bypass: got %h want 0000002200000022", rd_data);
        end
        tick();
        set_wr(0, 1'b1, 5'd10, 32'hAA);
        set_wr(1, 1'b1, 5'd11, 32'hBB);
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h22) begin
            errors++;
            $display("FAIL collide_array: got %h want 22", rd_data[31:0]);
        end
        tick();
        idle();
        set_rd(0, 5'd10); set_rd(1, 5'd11);
        #1;
        checks++;
        if (rd_data !== {32'hBB, 32'hAA}) begin
            errors++;
            $display("FAIL dual_write: got %h want 000000bb000000aa", rd_data);
        end
    endtask

    task automatic test_scoreboard();
        set_rd(0, 5'd9); set_rd(1, 5'd0);
        rsv_en = 1'b1; rsv_idx = 5'd9;
        #2;
        checks++;
        if (rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL rsv_same_cycle: busy=%b want 0", rd_busy[0]);
        end
        tick();
        rsv_en = 1'b0;
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL rsv_next: busy=%b want 1", rd_busy[0]);
        end
        set_wr(1, 1'b1, 5'd9, 32'h99);
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h99) begin
            errors++;
            $display("FAIL release_cycle: busy=%b data=%h want 0/99", rd_busy[0], rd_data[31:0]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL release_after: busy=%b want 0", rd_busy[0]);
        end
        rsv_en = 1'b1; rsv_idx = 5'd9;
        set_wr(0, 1'b1, 5'd9, 32'h77);
        tick();
        idle();
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h77) begin
            errors++;
            $display("FAIL rsv_wins: busy=%b data=%h want 1/77", rd_busy[0], rd_data[31:0]);
        end
        rsv_en = 1'b1; rsv_idx = 5'd0;
        set_wr(0, 1'b1, 5'd9, 32'h78);
        tick();
        idle();
        #1;
        checks++;
        if (rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL rsv_x0_and_release: busy=%b want 00", rd_busy);
        end
    endtask

    task automatic test_reset_mid_init();
        set_wr(1, 1'b1, 5'd3, 32'h55);
        rsv_en = 1'b1; rsv_idx = 5'd12;
        tick();
        idle();
        set_rd(0, 5'd3); set_rd(1, 5'd12);
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h55 || rd_busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst: data=%h busy=%b want 55/1", rd_data[31:0], rd_busy[1]);
        end
        pulse_rst();
        checks++;
        if (ready !== 1'b0 || rd_data !== 64'h0 || rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL rst_from_run: ready=%b data=%h busy=%b want 0/0/0", ready, rd_data, rd_busy);
        end
        for (int k = 0; k < 9; k++) tick();
        pulse_rst();
        for (int k = 1; k <= 32; k++) begin
            tick();
            checks++;
            if (ready !== ((k == 32) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL reinit_ready edge %0d: ready=%b want %b", k, ready, (k == 32));
            end
        end
        for (int r = 0; r < 32; r++) begin
            set_rd(0, 5'(r));
            #1;
            checks++;
            if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
                errors++;
                $display("FAIL reinit_x%0d: data=%h busy=%b want 0/0", r, rd_data[31:0], rd_busy[0]);
            end
        end
    endtask

    task automatic test_init_ignored();
        pulse_rst();
        set_wr(0, 1'b1, 5'd4, 32'hFFFF);
        set_wr(1, 1'b1, 5'd4, 32'hEEEE);
        rsv_en = 1'b1; rsv_idx = 5'd4;
        set_rd(0, 5'd4); set_rd(1, 5'd4);
        for (int k = 1; k <= 32; k++) begin
            #1;
            checks++;
            if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
                errors++;
                $display("FAIL init_read cycle %0d: data=%h busy=%b want 0/00", k, rd_data, rd_busy);
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (ready !== 1'b1 || rd_data !== 64'h0 || rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL init_ignored_x4: ready=%b data=%h busy=%b want 1/0/00", ready, rd_data, rd_busy);
        end
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_same_index();
        test_scoreboard();
        test_reset_mid_init();
        test_init_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
